// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: NPORTS ports of DW bits, each with an output
// register, a synchronised input view, rising-edge capture (write-1-to-clear)
// and an interrupt mask. Register map per port: 0 OUT, 1 IN, 2 EDGE, 3 IRQEN.
module mmio_gpio_bank #(
  parameter int  DW          = 8,
  parameter int  NPORTS      = 2,
  parameter int  SYNC_STAGES = 2,
  localparam int AW          = $clog2(NPORTS * 4)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 rw,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        data_in,
  output logic [DW-1:0]        data_out,
  input  logic [NPORTS*DW-1:0] gpio_in,
  output logic [NPORTS*DW-1:0] gpio_out,
  output logic                 irq
);

  // Edge capture stays disabled until the synchroniser and prev-sample
  // flops hold real input values rather than their reset zeros.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CW         = $clog2(ARM_CYCLES + 1);

  typedef enum logic [1:0] {
    REG_OUT   = 2'd0,
    REG_IN    = 2'd1,
    REG_EDGE  = 2'd2,
    REG_IRQEN = 2'd3
  } reg_e;

  logic [DW-1:0]        out_q   [NPORTS];
  logic [DW-1:0]        edge_q  [NPORTS];
  logic [DW-1:0]        irqen_q [NPORTS];
  logic [NPORTS*DW-1:0] sync_q  [SYNC_STAGES];
  logic [NPORTS*DW-1:0] prev_q;
  logic [NPORTS*DW-1:0] synced;
  logic [CW-1:0]        arm_cnt_q;
  logic                 armed;

  logic [AW-1:0]        port_sel;
  reg_e                 reg_sel;
  logic                 wr_en;
  logic [NPORTS-1:0]    hit;
  logic [DW-1:0]        set_v   [NPORTS];
  logic [DW-1:0]        clr_v   [NPORTS];
  logic [DW-1:0]        rd_mux;
  logic                 irq_next;

  assign port_sel = addr >> 2;
  assign reg_sel  = reg_e'(addr[1:0]);
  assign wr_en    = cs & ~rw;
  assign synced   = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt_q == CW'(ARM_CYCLES));

  // Port decode: an out-of-range port matches no hit bit, so it reads 0
  // and ignores writes instead of aliasing onto a real port.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      hit[p] = (32'(port_sel) == 32'(p));
    end
  end

  // Edge set/clear terms, read-data mux and the next interrupt level.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    rd_mux   = '0;
    irq_next = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      set_v[p] = armed ? (synced[p*DW +: DW] & ~prev_q[p*DW +: DW]) : '0;
      clr_v[p] = (wr_en && hit[p] && reg_sel == REG_EDGE) ? data_in : '0;
      irq_next = irq_next | (|(edge_q[p] & irqen_q[p]));
      if (hit[p]) begin
        case (reg_sel)
          REG_OUT:   rd_mux = out_q[p];
          REG_IN:    rd_mux = synced[p*DW +: DW];
          REG_EDGE:  rd_mux = edge_q[p];
          REG_IRQEN: rd_mux = irqen_q[p];
        endcase
      end
    end
  end

  // Input synchroniser chain, previous-sample register and arming counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the same
      // edge; blocking ones would collapse the chain into a single flop.
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= synced;
      if (!armed) arm_cnt_q <= arm_cnt_q + CW'(1);
    end
  end

  // Per-port OUT, IRQEN and EDGE registers; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these arrays are a handful of flops, not a RAM, so they take
      // the reset explicitly; a real memory array would not.
      for (int p = 0; p < NPORTS; p++) begin
        out_q[p]   <= '0;
        edge_q[p]  <= '0;
        irqen_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_en && hit[p] && reg_sel == REG_OUT)   out_q[p]   <= data_in;
        if (wr_en && hit[p] && reg_sel == REG_IRQEN) irqen_q[p] <= data_in;
        edge_q[p] <= (edge_q[p] & ~clr_v[p]) | set_v[p];
      end
    end
  end

  // Registered read data (held between reads) and interrupt request.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      if (cs && rw) data_out <= rd_mux;
      irq <= irq_next;
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_out
    assign gpio_out[p*DW +: DW] = out_q[p];
  end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank: a 2-port and a 3-port instance, a register-map
// model compared every cycle, plus hand-computed directed expectations.
module tb_mmio_gpio_bank;

  localparam int SS = 2;

  logic        clk;
  logic        reset;
  logic        cs_v   [2];
  logic        rw_v   [2];
  logic [3:0]  addr_v [2];
  logic [7:0]  din_v  [2];
  logic [23:0] gin_v  [2];

  logic [7:0]  dout_a, dout_b;
  logic [15:0] gout_a;
  logic [23:0] gout_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  mmio_gpio_bank #(.DW(8), .NPORTS(2), .SYNC_STAGES(SS)) dut_a (
    .clk(clk), .reset(reset), .cs(cs_v[0]), .rw(rw_v[0]),
    .addr(addr_v[0][2:0]), .data_in(din_v[0]), .data_out(dout_a),
    .gpio_in(gin_v[0][15:0]), .gpio_out(gout_a), .irq(irq_a)
  );

  mmio_gpio_bank #(.DW(8), .NPORTS(3), .SYNC_STAGES(SS)) dut_b (
    .clk(clk), .reset(reset), .cs(cs_v[1]), .rw(rw_v[1]),
    .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout_b),
    .gpio_in(gin_v[1]), .gpio_out(gout_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file per port, input history per cycle,
  // and a count of cycles since reset for edge arming.
  logic [7:0]  m_out  [2][8];
  logic [7:0]  m_edge [2][8];
  logic [7:0]  m_ien  [2][8];
  logic [23:0] m_hist [2][SS+1];
  int          m_cnt  [2];
  logic [7:0]  m_dout [2];
  logic        m_irq  [2];
  bit          started = 0;

  always @(posedge clk) begin : model
    int np, port, r;
    logic [3:0]  a;
    logic [7:0]  rv, setb, clrb;
    logic        irq_n;
    logic [23:0] syn, prv;
    started = 1;
    for (int i = 0; i < 2; i++) begin
      np = (i == 0) ? 2 : 3;
      if (reset) begin
        for (int p = 0; p < 8; p++) begin
          m_out[i][p] = 0; m_edge[i][p] = 0; m_ien[i][p] = 0;
        end
        for (int k = 0; k <= SS; k++) m_hist[i][k] = 0;
        m_cnt[i] = 0; m_dout[i] = 0; m_irq[i] = 0;
      end else begin
        a     = (i == 0) ? {1'b0, addr_v[0][2:0]} : addr_v[1];
        port  = int'(a) / 4;
        r     = int'(a) % 4;
        syn   = m_hist[i][SS-1];
        prv   = m_hist[i][SS];
        irq_n = 0;
        for (int p = 0; p < np; p++) irq_n = irq_n | (|(m_edge[i][p] & m_ien[i][p]));
        if (cs_v[i] && rw_v[i]) begin
          rv = 0;
          if (port < np) begin
            case (r)
              0: rv = m_out[i][port];
              1: rv = syn[port*8 +: 8];
              2: rv = m_edge[i][port];
              default: rv = m_ien[i][port];
            endcase
          end
          m_dout[i] = rv;
        end
        for (int p = 0; p < np; p++) begin
          setb = (m_cnt[i] >= SS + 1) ? (syn[p*8 +: 8] & ~prv[p*8 +: 8]) : 8'h00;
          clrb = (cs_v[i] && !rw_v[i] && port == p && r == 2) ? din_v[i] : 8'h00;
          m_edge[i][p] = (m_edge[i][p] & ~clrb) | setb;
          if (cs_v[i] && !rw_v[i] && port == p && r == 0) m_out[i][p] = din_v[i];
          if (cs_v[i] && !rw_v[i] && port == p && r == 3) m_ien[i][p] = din_v[i];
        end
        for (int k = SS; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = (i == 0) ? {8'h00, gin_v[0][15:0]} : gin_v[1];
        if (m_cnt[i] < 1000) m_cnt[i]++;
        m_irq[i] = irq_n;
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    logic [23:0] g;
    if (started) begin
      g = 0;
      for (int p = 0; p < 2; p++) g[p*8 +: 8] = m_out[0][p];
      check("a.data_out", 32'(dout_a), 32'(m_dout[0]));
      check("a.gpio_out", 32'(gout_a), 32'(g[15:0]));
      check("a.irq",      32'(irq_a),  32'(m_irq[0]));
      g = 0;
      for (int p = 0; p < 3; p++) g[p*8 +: 8] = m_out[1][p];
      check("b.data_out", 32'(dout_b), 32'(m_dout[1]));
      check("b.gpio_out", 32'(gout_b), 32'(g));
      check("b.irq",      32'(irq_b),  32'(m_irq[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input int i, input bit rd, input logic [3:0] a, input logic [7:0] d);
    cs_v[i] = 1'b1; rw_v[i] = rd; addr_v[i] = a; din_v[i] = d;
    step();
    cs_v[i] = 1'b0; rw_v[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cs_v[i] = 0; rw_v[i] = 0; addr_v[i] = 0; din_v[i] = 0;
    end
    gin_v[0] = 24'h0000FF;
    gin_v[1] = 24'h000000;
    reset    = 1'b1;
    repeat (3) step();
    check("reset.data_out", 32'(dout_a), 32'h0);
    check("reset.gpio_out", 32'(gout_a), 32'h0);

    // Inputs high through reset must not raise EDGE or irq.
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("armed.irq_quiet", 32'(irq_a), 32'h0);
    end
    bus(0, 1, 4'd2, 8'h00); check("armed.edge_zero", 32'(dout_a), 32'h00);
    bus(0, 1, 4'd1, 8'h00); check("in.read",         32'(dout_a), 32'hFF);

    // Output registers and read latency.
    bus(0, 0, 4'd0, 8'hA5);
    bus(0, 0, 4'd4, 8'h3C);
    check("out.gpio", 32'(gout_a), 32'h3CA5);
    bus(0, 1, 4'd4, 8'h00); check("out.read_p1", 32'(dout_a), 32'h3C);
    step();                  check("out.hold",    32'(dout_a), 32'h3C);

    // Rising edge on bit0 with mask set: EDGE at +3, irq at +4, W1C clears.
    gin_v[0] = 24'h0000FE;
    repeat (5) step();
    bus(0, 0, 4'd3, 8'h01);
    gin_v[0] = 24'h0000FF;
    repeat (3) step();
    check("edge.irq_at3", 32'(irq_a), 32'h0);
    bus(0, 1, 4'd2, 8'h00);
    check("edge.read", 32'(dout_a), 32'h01);
    check("edge.irq_at4", 32'(irq_a), 32'h1);
    bus(0, 0, 4'd2, 8'h01);
    check("w1c.irq_plus1", 32'(irq_a), 32'h1);
    step();
    check("w1c.irq_plus2", 32'(irq_a), 32'h0);

    // A set in the same cycle as a W1C on that bit wins.
    gin_v[0] = 24'h0000FE; repeat (4) step();
    gin_v[0] = 24'h0000FF; repeat (4) step();
    check("race.irq_pre", 32'(irq_a), 32'h1);
    gin_v[0] = 24'h0000FE; repeat (4) step();
    gin_v[0] = 24'h0000FF; repeat (2) step();
    bus(0, 0, 4'd2, 8'h01);
    check("race.irq_same", 32'(irq_a), 32'h1);
    step();
    check("race.irq_after", 32'(irq_a), 32'h1);
    bus(0, 1, 4'd2, 8'h00); check("race.edge_kept", 32'(dout_a), 32'h01);
    bus(0, 0, 4'd2, 8'h01);
    step();
    check("race.cleared", 32'(irq_a), 32'h0);

    // Three-port instance: out-of-range port 3 and irq from port 2.
    bus(1, 0, 4'd0,  8'h11);
    bus(1, 0, 4'd8,  8'h22);
    bus(1, 0, 4'd12, 8'h77);
    check("oor.gpio", 32'(gout_b), 32'h220011);
    bus(1, 1, 4'd13, 8'h00); check("oor.read13", 32'(dout_b), 32'h00);
    bus(1, 1, 4'd8,  8'h00); check("p2.read_out", 32'(dout_b), 32'h22);
    bus(1, 1, 4'd12, 8'h00); check("oor.read12", 32'(dout_b), 32'h00);
    bus(1, 0, 4'd11, 8'h80);
    gin_v[1] = 24'h800000;
    repeat (4) step();
    check("p2.irq", 32'(irq_b), 32'h1);
    bus(1, 0, 4'd10, 8'h80);
    step();
    check("p2.irq_clr", 32'(irq_b), 32'h0);

    // Reset during a read: result discarded, everything cleared, re-armed.
    gin_v[0] = 24'h0000FE; repeat (4) step();
    gin_v[0] = 24'h0000FF; repeat (5) step();
    check("rst.irq_before", 32'(irq_a), 32'h1);
    reset = 1'b1;
    bus(0, 1, 4'd0, 8'h00);
    reset = 1'b0;
    check("rst.data_out", 32'(dout_a), 32'h00);
    check("rst.gpio_out", 32'(gout_a), 32'h0000);
    check("rst.irq",      32'(irq_a),  32'h0);
    repeat (10) step();
    check("rst.irq_quiet", 32'(irq_a), 32'h0);
    bus(0, 1, 4'd2, 8'h00); check("rst.edge_zero", 32'(dout_a), 32'h00);
    gin_v[0] = 24'h0000FE; repeat (4) step();
    gin_v[0] = 24'h0000FF; repeat (3) step();
    bus(0, 1, 4'd2, 8'h00); check("rearm.edge", 32'(dout_a), 32'h01);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
